// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding, port indices,
// and bus widths.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam logic PORT_PROC = 1'b0;
  localparam logic PORT_AUX  = 1'b1;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

endpackage

// File: rtl/dmem_rd_track.sv
// Read-return tracker: a two-stage valid + port-tag shift register that lines
// each issued read up with the dmem output. Read data is steered to the
// port that issued it and forced to zero on every cycle without a return.
module dmem_rd_track
  import dmem_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_vld,
  input  logic              issue_port,
  input  logic [DATA_W-1:0] q_dmem,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata
);

  logic [1:0] stg_vld;
  logic [1:0] stg_port;

  // Shift issued reads through two stages; reset drops anything in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stg_vld  <= 2'b00;
      stg_port <= 2'b00;
    end else begin
      stg_vld  <= {stg_vld[0], issue_vld};
      stg_port <= {stg_port[0], issue_port};
    end
  end

  assign p0_rvalid = stg_vld[1] && (stg_port[1] == PORT_PROC);
  assign p1_rvalid = stg_vld[1] && (stg_port[1] == PORT_AUX);
  assign p0_rdata  = p0_rvalid ? q_dmem : '0;
  assign p1_rdata  = p1_rvalid ? q_dmem : '0;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter. Port 0 (processor) and port 1 (loader/debug)
// share one synchronous dmem. Ownership is held while the owner keeps
// requesting, but is handed over after BURST_MAX beats when the other port
// waits. Idle ties go to the port not served last.
//
// Handshake: a beat is accepted on a rising edge where req=1 and gnt=1;
// gnt depends only on the registered state, and the requester holds we,
// addr and wdata stable while req=1. Reads return rvalid/rdata for one
// cycle, two edges after acceptance.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
);

  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  arb_state_t state;
  logic [3:0] burst_cnt;
  logic [3:0] cnt_inc;
  logic       last_served;
  logic       ready;
  logic       acc0;
  logic       acc1;
  logic       rd_issue;
  logic       rd_port;

  assign p0_gnt = (state == ST_OWN0);
  assign p1_gnt = (state == ST_OWN1);
  assign acc0   = p0_req && p0_gnt;
  assign acc1   = p1_req && p1_gnt;

  // Beat count including the beat accepted at this edge, saturating.
  assign cnt_inc = ((acc0 || acc1) && (burst_cnt < BMAX)) ? burst_cnt + 4'd1 : burst_cnt;

  // Ownership FSM; 'ready' holds off the first grant for one edge after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      burst_cnt   <= 4'd0;
      last_served <= PORT_AUX;
      ready       <= 1'b0;
    end else begin
      ready <= 1'b1;
      case (state)
        ST_IDLE: begin
          burst_cnt <= 4'd0;
          if (ready) begin
            if (p0_req && p1_req) begin
              state <= (last_served == PORT_AUX) ? ST_OWN0 : ST_OWN1;
            end else if (p0_req) begin
              state <= ST_OWN0;
            end else if (p1_req) begin
              state <= ST_OWN1;
            end
          end
        end
        ST_OWN0: begin
          if (p0_req && !(p1_req && (cnt_inc == BMAX))) begin
            burst_cnt <= cnt_inc;
          end else begin
            burst_cnt   <= 4'd0;
            last_served <= PORT_PROC;
            state       <= p1_req ? ST_OWN1 : ST_IDLE;
          end
        end
        ST_OWN1: begin
          if (p1_req && !(p0_req && (cnt_inc == BMAX))) begin
            burst_cnt <= cnt_inc;
          end else begin
            burst_cnt   <= 4'd0;
            last_served <= PORT_AUX;
            state       <= p0_req ? ST_OWN0 : ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          burst_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Registered dmem drive: load the accepted beat, otherwise hold with wren low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      address_dmem <= '0;
      data         <= '0;
      wren         <= 1'b0;
      rd_issue     <= 1'b0;
      rd_port      <= PORT_PROC;
    end else begin
      wren     <= 1'b0;
      rd_issue <= 1'b0;
      if (acc0) begin
        address_dmem <= p0_addr;
        data         <= p0_wdata;
        wren         <= p0_we;
        rd_issue     <= !p0_we;
        rd_port      <= PORT_PROC;
      end else if (acc1) begin
        address_dmem <= p1_addr;
        data         <= p1_wdata;
        wren         <= p1_we;
        rd_issue     <= !p1_we;
        rd_port      <= PORT_AUX;
      end
    end
  end

  dmem_rd_track u_rd_track (
    .clock      (clock),
    .reset      (reset),
    .issue_vld  (rd_issue),
    .issue_port (rd_port),
    .q_dmem     (q_dmem),
    .p0_rvalid  (p0_rvalid),
    .p1_rvalid  (p1_rvalid),
    .p0_rdata   (p0_rdata),
    .p1_rdata   (p1_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural dmem, per-cycle grant table, read-data
// scoreboard, and hand-written sequences for writes, reset and bursts.
module tb_dmem_arbiter;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [11:0] p0_addr = '0, p1_addr = '0;
  logic [31:0] p0_wdata = '0, p1_wdata = '0;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, wren;
  logic [31:0] p0_rdata, p1_rdata, data;
  logic [11:0] address_dmem;
  logic [31:0] q_dmem = '0;

  dmem_arbiter #(.BURST_MAX(4)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .address_dmem(address_dmem), .data(data), .wren(wren),
    .q_dmem(q_dmem)
  );

  // ---------------- dmem model: address sampled at one edge, data out at the next ----------------
  function automatic logic [31:0] pat(input logic [11:0] a);
    if (a == 12'h005) return 32'hDEADBEEF;
    return {a, 8'h5A, a ^ 12'hC3C};
  endfunction

  logic [31:0] mem_data [4096];
  bit          mem_wr   [4096];
  logic [11:0] raddr_q = '0;

  always @(posedge clock) begin
    if (wren) begin
      mem_data[address_dmem] <= data;
      mem_wr[address_dmem]   <= 1'b1;
    end
    raddr_q <= address_dmem;
    q_dmem  <= mem_wr[raddr_q] ? mem_data[raddr_q] : pat(raddr_q);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] shadow [4096];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int          exp_c0[$];
  int          exp_c1[$];
  int          acc_cnt0 = 0;
  int          p1_snap  = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at the negedge where the bench sees req&gnt: acceptance is the next posedge.
  task automatic sb_push(input int port, input logic we, input logic [11:0] addr, input logic [31:0] wd);
    if (port == 0) acc_cnt0++;
    else p1_snap = acc_cnt0;
    if (we) begin
      shadow[addr] = wd;
    end else if (port == 0) begin
      exp_q0.push_back(shadow[addr]);
      exp_c0.push_back(cyc + 3);
    end else begin
      exp_q1.push_back(shadow[addr]);
      exp_c1.push_back(cyc + 3);
    end
  endtask

  task automatic mon_port(input int port, input logic rv, input logic [31:0] rd);
    logic [31:0] d;
    int c;
    if (rv) begin
      if ((port == 0 && exp_q0.size() == 0) || (port == 1 && exp_q1.size() == 0)) begin
        n_checks++;
        n_fail++;
        $display("FAIL rvalid_unexpected_p%0d: actual rvalid=1 required rvalid=0 (cycle %0d)", port, cyc);
      end else begin
        if (port == 0) begin d = exp_q0.pop_front(); c = exp_c0.pop_front(); end
        else begin d = exp_q1.pop_front(); c = exp_c1.pop_front(); end
        check($sformatf("rdata_p%0d", port), rd, d);
        check($sformatf("rvalid_cycle_p%0d", port), 32'(cyc), 32'(c));
      end
    end else begin
      check($sformatf("rdata_idle_zero_p%0d", port), rd, 32'h0);
    end
  endtask

  always @(negedge clock) begin
    mon_port(0, p0_rvalid, p0_rdata);
    mon_port(1, p1_rvalid, p1_rdata);
  end

  // ---------------- driver tasks ----------------
  task automatic drive_port(input int port, input logic req, input logic we,
                            input logic [11:0] addr, input logic [31:0] wd);
    if (port == 0) begin p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wd; end
    else begin p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wd; end
  endtask

  task automatic release_port(input int port);
    if (port == 0) p0_req = 1'b0;
    else p1_req = 1'b0;
  endtask

  // Present one beat at a negedge and hold it until granted (bounded).
  task automatic beat(input int port, input logic we, input logic [11:0] addr,
                      input logic [31:0] wd, output int waited);
    int  k = 0;
    bit  got = 0;
    drive_port(port, 1'b1, we, addr, wd);
    while (!got && k < 40) begin
      if ((port == 0 && p0_gnt) || (port == 1 && p1_gnt)) begin
        got = 1;
        sb_push(port, we, addr, wd);
      end else begin
        k++;
      end
      @(negedge clock);
    end
    waited = k;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_timeout_p%0d: actual no grant in 40 cycles, required grant", port);
    end
  endtask

  task automatic apply_reset(input int settle);
    @(negedge clock);
    reset = 1'b0;
    exp_q0.delete(); exp_q1.delete(); exp_c0.delete(); exp_c1.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (settle) @(negedge clock);
  endtask

  task automatic drain(input string name);
    repeat (5) @(negedge clock);
    check(name, 32'(exp_q0.size() + exp_q1.size()), 32'h0);
  endtask

  // ---------------- grant table ----------------
  typedef struct packed {
    logic r0;
    logic r1;
    logic g0;
    logic g1;
  } vec_t;
  vec_t vecs [24];

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: actual time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int w;
    logic [11:0] a0, a1, prev_addr;
    bit prev_acc;

    for (int i = 0; i < 4096; i++) shadow[i] = pat(12'(i));
    //          r0 r1 g0 g1
    vecs = '{4'b1100, 4'b1100, 4'b1110, 4'b1110, 4'b1110, 4'b1110,
             4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1110, 4'b1110,
             4'b0110, 4'b0101, 4'b0001, 4'b0000, 4'b0100, 4'b1101,
             4'b0001, 4'b1100, 4'b0010, 4'b1100, 4'b0001, 4'b0000};

    // Reset state with both ports requesting writes: nothing may move.
    drive_port(0, 1'b1, 1'b1, 12'h0AA, 32'h11111111);
    drive_port(1, 1'b1, 1'b1, 12'h0BB, 32'h22222222);
    repeat (3) @(negedge clock);
    check("rst_gnt", {30'd0, p0_gnt, p1_gnt}, 32'h0);
    check("rst_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'h0);
    check("rst_rdata0", p0_rdata, 32'h0);
    check("rst_rdata1", p1_rdata, 32'h0);
    check("rst_wren", {31'd0, wren}, 32'h0);
    check("rst_addr", {20'd0, address_dmem}, 32'h0);
    check("rst_data", data, 32'h0);

    // Release reset at a negedge and walk the grant table from that point.
    reset = 1'b1;
    a0 = 12'h040; a1 = 12'h800; prev_acc = 0; prev_addr = '0;
    for (int i = 0; i < 24; i++) begin
      drive_port(0, vecs[i].r0, 1'b0, a0, 32'h0);
      drive_port(1, vecs[i].r1, 1'b0, a1, 32'h0);
      check($sformatf("tbl_gnt_%0d", i), {30'd0, p0_gnt, p1_gnt}, {30'd0, vecs[i].g0, vecs[i].g1});
      if (prev_acc) check($sformatf("tbl_addr_%0d", i), {20'd0, address_dmem}, {20'd0, prev_addr});
      check($sformatf("tbl_wren_%0d", i), {31'd0, wren}, 32'h0);
      prev_acc = 0;
      if (vecs[i].r0 && vecs[i].g0) begin
        sb_push(0, 1'b0, a0, 32'h0); prev_acc = 1; prev_addr = a0; a0 = a0 + 12'd1;
      end
      if (vecs[i].r1 && vecs[i].g1) begin
        sb_push(1, 1'b0, a1, 32'h0); prev_acc = 1; prev_addr = a1; a1 = a1 + 12'd1;
      end
      @(negedge clock);
    end
    release_port(0); release_port(1);
    drain("tbl_drain");

    // Single processor read of 0x005.
    apply_reset(1);
    beat(0, 1'b0, 12'h005, 32'h0, w);
    check("p0_first_gnt_wait", 32'(w), 32'd1);
    release_port(0);
    drain("single_read_drain");

    // Aux write to the top address, then back-to-back reads of it and of 0x000.
    apply_reset(1);
    beat(1, 1'b1, 12'hFFF, 32'h12345678, w);
    check("wr_wren", {31'd0, wren}, 32'h1);
    check("wr_addr", {20'd0, address_dmem}, 32'h00000FFF);
    check("wr_data", data, 32'h12345678);
    beat(1, 1'b0, 12'hFFF, 32'h0, w);
    check("raw_b2b_wait", 32'(w), 32'd0);
    check("wren_one_cycle", {31'd0, wren}, 32'h0);
    check("raw_addr", {20'd0, address_dmem}, 32'h00000FFF);
    beat(1, 1'b0, 12'h000, 32'h0, w);
    check("wrap_addr", {20'd0, address_dmem}, 32'h0);
    release_port(1);
    drain("raw_drain");

    // Reset asserted one cycle after a read acceptance drops the read.
    apply_reset(1);
    beat(0, 1'b0, 12'h020, 32'h0, w);
    check("pre_rst_addr", {20'd0, address_dmem}, 32'h00000020);
    reset = 1'b0;
    #1;
    check("async_rst_addr", {20'd0, address_dmem}, 32'h0);
    check("async_rst_gnt", {31'd0, p0_gnt}, 32'h0);
    check("async_rst_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'h0);
    check("async_rst_rdata", p0_rdata, 32'h0);
    release_port(0);
    exp_q0.delete(); exp_c0.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check($sformatf("no_rvalid_after_rst_%0d", i), {31'd0, p0_rvalid}, 32'h0);
    end

    // Processor streams 10 reads while aux waits for one read.
    apply_reset(1);
    acc_cnt0 = 0; p1_snap = -1;
    fork
      begin
        int w0;
        for (int i = 0; i < 10; i++) beat(0, 1'b0, 12'(12'h100 + i), 32'h0, w0);
        release_port(0);
      end
      begin
        int w1;
        beat(1, 1'b0, 12'h200, 32'h0, w1);
        release_port(1);
      end
    join
    check("p1_gnt_after_beat", 32'(p1_snap), 32'd4);
    check("p0_beats", 32'(acc_cnt0), 32'd10);
    drain("stream_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
